// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: round-robin arbitration of ALU and load writebacks onto the
// single register-file write port, plus a load scoreboard for decode hazard stalls.
module regfile_wb_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_addr,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        stall,
    output logic [31:0] busy_vec,
    output logic        reg_write,
    output logic [4:0]  write_addr,
    output logic [31:0] write_d,
    output logic        err
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    logic                prio;
    logic                src_mem;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                grant;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                rsv_err;
    logic                mem_err;

    // Round-robin grant: prio picks the winner only when both requesters are valid
    always_comb begin
        alu_ready = alu_valid && (!mem_valid || !prio);
        mem_ready = mem_valid && (!alu_valid || prio);
        grant     = alu_ready || mem_ready;
        win_addr  = mem_ready ? mem_addr : alu_addr;
        win_data  = mem_ready ? mem_data : alu_data;
    end

    // Loads clear their reservation on the same edge the register file is written
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (rsv_valid && (rsv_addr != '0)) begin
            set_vec[rsv_addr] = 1'b1;
        end
        if (reg_write && src_mem) begin
            clr_vec[write_addr] = 1'b1;
        end
        busy_next = (busy & ~clr_vec) | set_vec;
        rsv_err   = rsv_valid && (rsv_addr != '0) && busy[rsv_addr] && !clr_vec[rsv_addr];
        mem_err   = mem_ready && (mem_addr != '0) && !busy[mem_addr];
    end

    assign stall    = busy[rs1_addr] | busy[rs2_addr];
    assign busy_vec = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio       <= 1'b0;
            src_mem    <= 1'b0;
            busy       <= '0;
            reg_write  <= 1'b0;
            write_addr <= '0;
            write_d    <= '0;
            err        <= 1'b0;
        end else begin
            busy <= busy_next;
            if (rsv_err || mem_err) begin
                err <= 1'b1;
            end
            if (grant) begin
                prio       <= alu_ready;
                src_mem    <= mem_ready;
                write_addr <= win_addr;
                write_d    <= win_data;
                reg_write  <= (win_addr != '0);
            end else begin
                reg_write  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: reset, arbitration, scoreboard timing,
// set/clear collision, address-0 handling and the sticky error flag.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        stall;
    logic [31:0] busy_vec;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_d;
    logic        err;

    logic [31:0] rf [32];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .stall      (stall),
        .busy_vec   (busy_vec),
        .reg_write  (reg_write),
        .write_addr (write_addr),
        .write_d    (write_d),
        .err        (err)
    );

    // Register file model fed by the write port
    always_ff @(posedge clk) begin
        if (reg_write) rf[write_addr] <= write_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int ai;
        int mi;
        logic alu_win;
        rs1_addr = '0;
        rs2_addr = '0;
        do_reset();

        // Reset with activity in flight
        alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h55;
        rsv_valid = 1'b1; rsv_addr = 5'd6;
        step();
        check("pre_rst_reg_write", 32'(reg_write), 32'd1);
        check("pre_rst_busy", busy_vec, 32'h0000_0040);
        rsv_valid = 1'b0;
        alu_addr = 5'd5; alu_data = 32'h1234;
        rst = 1'b1;
        #1;
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_busy", busy_vec, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step();
        check("rst_hold_reg_write", 32'(reg_write), 32'd0);
        rst = 1'b0;
        #1;
        check("first_grant", {30'd0, alu_ready, mem_ready}, 32'd2);
        step();
        check("first_wr", 32'(reg_write), 32'd1);
        check("first_addr", 32'(write_addr), 32'd5);
        check("first_data", write_d, 32'h1234);
        idle();
        step();
        check("no_grant_wr", 32'(reg_write), 32'd0);

        // Contention: alternate starting with ALU, no request lost
        do_reset();
        for (int r = 8; r < 12; r++) begin
            rsv_valid = 1'b1; rsv_addr = 5'(r);
            step();
        end
        rsv_valid = 1'b0;
        check("rsv_busy_8_11", busy_vec, 32'h0000_0F00);
        ai = 0;
        mi = 0;
        for (int k = 0; k < 8; k++) begin
            alu_valid = (ai < 4); alu_addr = 5'(ai + 1); alu_data = 32'h100 + 32'(ai);
            mem_valid = (mi < 4); mem_addr = 5'(mi + 8); mem_data = 32'h200 + 32'(mi);
            alu_win = ((k % 2) == 0);
            #1;
            check($sformatf("arb_grant%0d", k), {30'd0, alu_ready, mem_ready},
                  alu_win ? 32'd2 : 32'd1);
            step();
            check($sformatf("arb_addr%0d", k), 32'(write_addr),
                  alu_win ? 32'(ai + 1) : 32'(mi + 8));
            check($sformatf("arb_data%0d", k), write_d,
                  alu_win ? 32'h100 + 32'(ai) : 32'h200 + 32'(mi));
            if (alu_win) ai++; else mi++;
        end
        idle();
        step();
        step();
        check("arb_busy_clear", busy_vec, 32'd0);
        check("arb_err", 32'(err), 32'd0);

        // Scoreboard timing for a load to r7
        rs1_addr = 5'd7;
        #1;
        check("sb_stall_c0", 32'(stall), 32'd0);
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        step();
        rsv_valid = 1'b0;
        check("sb_busy_c1", busy_vec, 32'h0000_0080);
        check("sb_stall_c1", 32'(stall), 32'd1);
        step();
        step();
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'hCAFE;
        #1;
        check("sb_mem_ready_c3", 32'(mem_ready), 32'd1);
        step();
        idle();
        #1;
        check("sb_stall_c4", 32'(stall), 32'd1);
        check("sb_wr_c4", {26'd0, reg_write, write_addr}, {26'd0, 1'b1, 5'd7});
        check("sb_data_c4", write_d, 32'hCAFE);
        step();
        check("sb_stall_c5", 32'(stall), 32'd0);
        check("sb_rf_c5", rf[7], 32'hCAFE);
        rs1_addr = '0;
        check("sb_err", 32'(err), 32'd0);

        // Set and clear of r9 on the same edge
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        step();
        rsv_valid = 1'b0;
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h99;
        step();
        idle();
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        step();
        rsv_valid = 1'b0;
        check("col_busy", busy_vec, 32'h0000_0200);
        check("col_err", 32'(err), 32'd0);
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h9A;
        step();
        idle();
        step();
        check("col_busy_clr", busy_vec, 32'd0);
        check("col_err2", 32'(err), 32'd0);

        // Address 0 handshakes, never writes, still rotates prio
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hDEAD;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        check("a0_alu_ready", 32'(alu_ready), 32'd1);
        step();
        rsv_valid = 1'b0;
        check("a0_wr", 32'(reg_write), 32'd0);
        check("a0_busy", busy_vec, 32'd0);
        check("a0_stall", 32'(stall), 32'd0);
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hBEEF;
        #1;
        check("a0_prio_rot", {30'd0, alu_ready, mem_ready}, 32'd1);
        step();
        idle();
        check("a0_wr2", 32'(reg_write), 32'd0);
        check("a0_err", 32'(err), 32'd0);

        // Double reservation is a sticky error
        do_reset();
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        step();
        check("err_first_rsv", 32'(err), 32'd0);
        step();
        rsv_valid = 1'b0;
        check("err_double_rsv", 32'(err), 32'd1);
        step();
        step();
        check("err_sticky", 32'(err), 32'd1);

        // Load writeback to a register with no reservation
        do_reset();
        check("err_after_rst", 32'(err), 32'd0);
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h44;
        step();
        idle();
        check("err_unreserved_mem", 32'(err), 32'd1);
        check("unreserved_wr", {26'd0, reg_write, write_addr}, {26'd0, 1'b1, 5'd4});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Writeback controller for the 32x32 register file. It shares the file's single write port between two writeback requesters: ALU results and memory loads. Arbitration is round-robin. It drives registered write-port signals and keeps a per-register scoreboard of outstanding loads, so decode can stall on read-after-write hazards. It sits between the execute/memory stages and the register file write port.

## Interface
- No parameters. Data width is fixed at 32 and address width at 5.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_addr  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU request granted this cycle (combinational)
- mem_valid  in  1  load writeback request
- mem_addr  in  5  load destination register
- mem_data  in  32  load data
- mem_ready  out  1  load request granted this cycle (combinational)
- rsv_valid  in  1  load issued; reserve destination register
- rsv_addr  in  5  register to mark busy
- rs1_addr, rs2_addr  in  5 each  decode source registers
- stall  out  1  busy[rs1_addr] | busy[rs2_addr] (combinational)
- busy_vec  out  32  scoreboard; bit 0 is always 0
- reg_write  out  1  to register file write enable (registered)
- write_addr  out  5  to register file write address (registered)
- write_d  out  32  to register file write data (registered)
- err  out  1  sticky scoreboard protocol error

## Operation
- Handshake: a transfer occurs when valid && ready. A requester must hold valid, addr and data stable until ready. At most one ready is high per cycle, and ready is never high without valid.
- Arbitration: one-bit pointer prio; 0 favours ALU, 1 favours MEM. With a single valid request, that request is granted. With both valid, the favoured one is granted. After any grant to requester i, prio <= other requester. prio is unchanged with no grant.
- Output stage: on a grant, the edge loads write_addr and write_d from the winner and a source tag from the winner. reg_write <= 1 if the address is nonzero. With no grant, or address 0, reg_write <= 0. write_addr and write_d hold their last values when reg_write is 0.
- Address 0 requests complete the handshake, consume the grant and rotate prio, but never produce reg_write=1.
- Scoreboard set: rsv_valid with rsv_addr != 0 sets busy[rsv_addr] at the edge.
- Scoreboard clear: taken from the output stage. If reg_write=1 and the source tag is MEM, busy[write_addr] clears at that edge, the same edge on which the register file writes. ALU writebacks never clear busy.
- Set and clear of the same register at the same edge: set wins, and the bit stays 1.
- err is set (sticky until rst) in either case:
  - rsv_valid to a nonzero register that is already busy and not being cleared that edge;
  - a MEM handshake to a nonzero register whose busy bit is 0 in the handshake cycle.
- stall reads busy_vec combinationally. rs*_addr = 0 never stalls.
- Reset values: busy_vec = 0, prio = 0, reg_write = 0, write_addr = 0, write_d = 0, source tag = ALU, err = 0. alu_ready and mem_ready follow the inputs; they are 0 while both valids are 0.

## Timing
- Handshake in cycle N: reg_write, write_addr and write_d are valid during cycle N+1. The register file captures the data at the end of N+1, and it is readable in N+2.
- busy for a load clears at the end of N+1, so stall drops in N+2, the same cycle the data becomes readable.
- Back-to-back grants: one per cycle, sustained. Throughput is 1 write per cycle.
- rsv in cycle M: busy and stall are visible in M+1.
- rst asserted mid-operation: all state clears immediately and asynchronously, and any in-flight writeback is dropped. The output stage shows reg_write=0 while rst is high and on the first edge after rst falls, unless a grant occurs in that cycle.

## Test plan
- Reset: assert rst with a pending request → reg_write=0, busy_vec=0, err=0. Release rst; alu_valid, alu_addr=5, alu_data=0x1234 → alu_ready=1 in cycle N; reg_write=1, write_addr=5, write_d=0x1234 in N+1.
- Contention: both valid for 4 cycles (ALU r1..r4, MEM r8..r11, each with busy preset) → grants alternate ALU, MEM, ALU, MEM starting with ALU. Each stalled requester holds its request until granted, with no loss.
- Scoreboard: rsv r7 in cycle 0 → busy_vec[7]=1 in cycle 1; rs1_addr=7 → stall=1. MEM writeback r7=0xCAFE handshake in cycle 3 → stall stays 1 through cycle 4 and drops in cycle 5; register file r7=0xCAFE in cycle 5.
- Set and clear collide: a clear of r9 from the output stage at the same edge as rsv r9 → busy[9] stays 1 and err stays 0.
- Address 0: alu_addr=0 and rsv r0 → handshake completes, reg_write=0, busy_vec[0]=0, prio rotates.
- Errors: rsv r3 twice with no clear → err=1 and stays 1. After rst, a MEM writeback to r4 with busy[4]=0 → err=1.
